// File: rtl/ltc2320_pkg.sv
// Shared constants and types for the LTC2320-16 capture block and its emulator.
package ltc2320_pkg;
    localparam int LTC2320_LANES = 8;
    localparam int LTC2320_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SHIFT,
        DONE
    } ltc2320_state_t;

    typedef logic [LTC2320_BITS-1:0] ltc2320_word_t;
endpackage

// File: rtl/ltc2320_emu_sync.sv
// Multi-stage synchronizer followed by a one-stage edge detector for an asynchronous pin.
module ltc2320_emu_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;
    logic              level;

    // Reset to the pin's idle level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {STAGES{IDLE_VAL}};
            prev_reg  <= IDLE_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], async_in};
            prev_reg  <= level;
        end
    end

    assign level = chain_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;
endmodule

// File: rtl/ltc2320_emulator.sv
// Responder model of the LTC2320-16 8-lane serial ADC.
// Define LTC2320_EMU_PATTERN_EN to replace ch_data with an internal per-conversion ramp.
module ltc2320_emulator
    import ltc2320_pkg::*;
#(
    parameter int CONV_CYCLES = 45,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                       clk_sys,
    input  logic                                       reset_sys_n,
    input  logic                                       adc_sck,
    input  logic                                       adc_cnv_n,
    output logic [LTC2320_LANES-1:0]                   adc_sdo,
    output logic                                       adc_sdo_oe,
    output logic                                       adc_clkout,
    input  logic [LTC2320_LANES-1:0][LTC2320_BITS-1:0] ch_data,
    output logic                                       busy,
    output logic                                       proto_err,
    output logic [15:0]                                conv_count
);
    localparam int CW = $clog2(CONV_CYCLES + 1);

    logic sck_rise, sck_fall, cnv_rise, cnv_fall;

    ltc2320_emu_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
        .clk(clk_sys), .rst_n(reset_sys_n), .async_in(adc_sck),
        .rise(sck_rise), .fall(sck_fall)
    );

    ltc2320_emu_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cnv (
        .clk(clk_sys), .rst_n(reset_sys_n), .async_in(adc_cnv_n),
        .rise(cnv_rise), .fall(cnv_fall)
    );

    ltc2320_state_t                     state_reg, state_next;
    logic [CW-1:0]                      cnt_reg;
    logic [3:0]                         bit_cnt_reg;
    logic [LTC2320_LANES-1:0][LTC2320_BITS-1:0] shift_reg;
    ltc2320_word_t                      snap_word [LTC2320_LANES];
    logic [LTC2320_LANES-1:0]           lane_msb;
    logic [15:0]                        conv_count_reg;
    logic                               clkout_reg;
    logic                               proto_err_reg;
    logic                               start;
    logic                               err_set;

    assign start = (state_reg == IDLE) && cnv_fall && !cnv_rise;

`ifdef LTC2320_EMU_PATTERN_EN
    ltc2320_word_t ramp_reg;

    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n)
            ramp_reg <= '0;
        else if (start)
            ramp_reg <= ramp_reg + 16'd1;
    end
`endif

    for (genvar gi = 0; gi < LTC2320_LANES; gi++) begin : g_lane
`ifdef LTC2320_EMU_PATTERN_EN
        assign snap_word[gi] = ramp_reg + ltc2320_word_t'(gi << 12);
`else
        assign snap_word[gi] = ch_data[gi];
`endif
        assign lane_msb[gi] = shift_reg[gi][LTC2320_BITS-1];
    end

    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // DONE is entered on the 16th fall, after bit 0 has been on the lanes for a full SCK period.
    always_comb begin
        state_next = state_reg;
        if (cnv_rise) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (cnv_fall) state_next = CONVERT;
                CONVERT: if (cnt_reg == '0) state_next = SHIFT;
                SHIFT:   if (sck_fall && bit_cnt_reg == 4'd15) state_next = DONE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        adc_sdo_oe = 1'b0;
        adc_sdo    = '0;
        case (state_reg)
            CONVERT: begin
                busy       = 1'b1;
                adc_sdo_oe = 1'b1;
            end
            SHIFT: begin
                adc_sdo_oe = 1'b1;
                adc_sdo    = lane_msb;
            end
            DONE:    adc_sdo_oe = 1'b1;
            default: adc_sdo_oe = 1'b0;
        endcase
    end

    assign err_set = cnv_rise ? (state_reg == CONVERT || state_reg == SHIFT)
                              : (state_reg == CONVERT && sck_fall);

    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            cnt_reg        <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            conv_count_reg <= '0;
            clkout_reg     <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            proto_err_reg <= err_set;
            if (sck_rise)
                clkout_reg <= 1'b1;
            else if (sck_fall)
                clkout_reg <= 1'b0;

            if (start) begin
                for (int i = 0; i < LTC2320_LANES; i++)
                    shift_reg[i] <= snap_word[i];
                conv_count_reg <= conv_count_reg + 16'd1;
                cnt_reg        <= CW'(CONV_CYCLES - 1);
            end else if (!cnv_rise && state_reg == CONVERT) begin
                if (cnt_reg != '0)
                    cnt_reg <= cnt_reg - 1'b1;
                else
                    bit_cnt_reg <= '0;
            end else if (!cnv_rise && state_reg == SHIFT && sck_fall) begin
                for (int i = 0; i < LTC2320_LANES; i++)
                    shift_reg[i] <= {shift_reg[i][LTC2320_BITS-2:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
        end
    end

    assign adc_clkout = clkout_reg;
    assign proto_err  = proto_err_reg;
    assign conv_count = conv_count_reg;
endmodule
